// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_bit.sv
// One-bit combinational full adder; the only arithmetic cell of the serial adder.
module serial_add_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder producing {carry, sum} over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sh, a_sh_d;
    logic [WIDTH-1:0] b_sh, b_sh_d;
    logic [WIDTH-1:0] sum_sh, sum_sh_d;
    logic             carry, carry_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             in_ready_d;
    logic             out_valid_d;
    logic [WIDTH:0]   o_d;
    logic             cell_b;
    logic             cell_s;
    logic             cell_co;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;
    assign cell_b = b_sh[0] ^ sub_q;
`else
    assign cell_b = b_sh[0];
`endif

    serial_add_bit u_bit (
        .a  (a_sh[0]),
        .b  (cell_b),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Next-state and next-register values for the whole datapath
    always_comb begin
        state_d     = state;
        a_sh_d      = a_sh;
        b_sh_d      = b_sh;
        sum_sh_d    = sum_sh;
        carry_d     = carry;
        cnt_d       = cnt;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        o_d         = o;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d       = sub_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    sum_sh_d   = '0;
                    cnt_d      = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d      = sub;
                    carry_d    = sub;
`else
                    carry_d    = 1'b0;
`endif
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh >> 1;
                b_sh_d   = b_sh >> 1;
                sum_sh_d = WIDTH'({cell_s, sum_sh} >> 1);
                carry_d  = cell_co;
                cnt_d    = cnt + CW'(1);
                // Last bit: publish the finished result from the same edge
                if (cnt == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    o_d         = {cell_co, sum_sh_d};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            o         <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            a_sh      <= a_sh_d;
            b_sh      <= b_sh_d;
            sum_sh    <= sum_sh_d;
            carry     <= carry_d;
            cnt       <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            o         <= o_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= sub_d;
`endif
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first adder that produces the same `{carry, sum}` result format as the parallel ripple-carry adder. It uses one full-adder bit cell and a carry flip-flop, iterated over WIDTH cycles. It sits in the datapath where area matters more than latency. Operands enter through a valid/ready input handshake, and the WIDTH+1-bit result leaves through a valid/ready output handshake.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits; legal range ≥ 1.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operands `a`, `b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: first operand, unsigned.
- `b`  in  WIDTH: second operand, unsigned.
- `sub`  in  1: subtract request (a − b); present only with `SERIAL_ADDER_SUB_EN`.
- `out_valid`  out  1: `o` holds a completed result.
- `out_ready`  in  1: consumer accepts `o`.
- `o`  out  WIDTH+1: `{carry, sum}`; bit WIDTH is the final carry.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`: capture `a` and `b` into shift registers, clear the bit counter, load the carry register with 0 (or with `sub` when enabled), then go to RUN.
  - RUN: each cycle the bit cell adds `a_sh[0]`, `b_sh[0]` (inverted when `sub` was captured) and the carry.
    - The sum bit shifts into the sum register from the MSB side.
    - `a_sh` and `b_sh` shift right.
    - The carry register takes the cell carry-out.
    - The counter increments. After the WIDTH-th bit, go to DONE.
  - DONE: `out_valid`=1 and `o` = `{carry_reg, sum_sh}`, held stable. On `out_ready`, go to IDLE.
- Counter is `$clog2(WIDTH+1)` bits. The RUN→DONE transition happens when counter == WIDTH−1 at the clock edge.
- Arithmetic is modulo 2^(WIDTH+1) in `o`. No overflow flag.
- `in_ready` is asserted only in IDLE. `in_valid` in RUN or DONE is ignored, and operands are not sampled.
- `a`, `b` and `sub` are sampled only on the accepting edge. Later changes on those inputs have no effect.
- `out_valid` and `o` must not change while `out_valid`=1 and `out_ready`=0.
- `out_ready` asserted outside DONE has no effect.
- Reset in any state, including mid-RUN, has these effects:
  - State returns to IDLE next cycle.
  - The partial result is discarded.
  - `out_valid`=0 and `in_ready`=1.
  - `o`=0, and shift registers, carry and counter are all 0.
- Reset takes priority over all handshakes in the same cycle.

## Timing
- Accept edge T (IDLE, `in_valid`=1) is followed by RUN for edges T+1 … T+WIDTH.
- `out_valid` is high from the cycle after edge T+WIDTH. Latency from the accept edge to `out_valid` is WIDTH+1 cycles... precisely: `out_valid` is high in cycle T+WIDTH+1.
- Result is accepted at edge R (DONE, `out_ready`=1). `in_ready`=1 in cycle R+1.
- Minimum issue interval is WIDTH+2 cycles with `out_ready` tied high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - The `sub` port exists and is captured at the accept edge.
  - When `sub`=1, the block computes a + ~b + 1. `o[WIDTH]`=1 means no borrow (a ≥ b).
- `SERIAL_ADDER_SUB_EN` undefined:
  - There is no `sub` port.
  - The carry-in is always 0 and `b` is never inverted.

## Structure
- `serial_adder_pkg` contains:
  - the FSM state enum typedef (`IDLE`, `RUN`, `DONE`);
  - no width constants, since WIDTH stays a module parameter.
- Sub-module `serial_add_bit` is a combinational one-bit full adder with ports `a`, `b`, `ci`, `s`, `co`. It is instantiated once.
- The top module holds the FSM, the shift registers, the carry flip-flop and the counter.

## Test plan
All scenarios use WIDTH=4.
- 5+3, `out_ready`=1 → `out_valid` in cycle T+5, `o`=5'b01000, `in_ready` back the next cycle.
- 15+15 → `o`=5'b11110. Then 0+0 → `o`=5'b00000, confirming the carry register was cleared between operations.
- 9+7 with `out_ready`=0 for 6 cycles in DONE → `o`=5'b10000 held stable. `in_valid`=1 with new operands during that time is not accepted. Releasing `out_ready` completes one transfer.
- Accept 6+6, assert `rst` at RUN bit 2 → next cycle IDLE, `out_valid`=0, `o`=0. Then accept 1+2 → `o`=5'b00011.
- With `SERIAL_ADDER_SUB_EN`: 5−3 → `o`=5'b10010; 3−5 → `o`=5'b01110.
- Back-to-back random operands with random `out_ready` for 1000 operations → every `o` equals a+b (or a−b mod 2^5 with the borrow bit) and results arrive in order.
